horizontal_frame_buffer: RTL and testbench

- Downstream of the horizontal output router; consumes its eight 64-bit lane outputs and their per-lane write codes.
- Collects one 16-cycle horizontal frame of 60 words into register storage.
- Drains the frame in fixed bank-major order over a valid/ready stream to the next pipeline stage.

---
 rtl/horizontal_frame_buffer_if.sv | 43 ++++
 rtl/horizontal_frame_buffer.sv | 171 +++++++++++++++++
 tb/tb_horizontal_frame_buffer.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/horizontal_frame_buffer_if.sv
// ============================================================================
// Module      : horizontal_frame_buffer_if
// Description : Bus bundle for horizontal_frame_buffer. It carries the eight
//               router lanes with their write codes into the buffer, and the
//               valid/ready drain stream out of it.
// Ports       : rom_in[7:0]   lane data, one P_WIDTH word per lane
//               rom0_w        bank0 write enable
//               rom_w[7:1]    banks 1..7 write code (0 none, 1 A, 2 B, 3 bad)
//               out_ready     downstream ready
//               out_valid     drain word valid
//               out_data      drain word
//               out_idx       drain index 0..59
//               out_last      high with the final index
// Modports    : master (router / downstream side), slave (frame buffer)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface horizontal_frame_buffer_if #(
  parameter int P_WIDTH   = 64,
  parameter int IDX_WIDTH = 6
);
  logic [7:0][P_WIDTH-1:0] rom_in;
  logic                    rom0_w;
  logic [7:1][1:0]         rom_w;
  logic                    out_ready;
  logic                    out_valid;
  logic [P_WIDTH-1:0]      out_data;
  logic [IDX_WIDTH-1:0]    out_idx;
  logic                    out_last;

  modport master (
    output rom_in, rom0_w, rom_w, out_ready,
    input  out_valid, out_data, out_idx, out_last
  );

  modport slave (
    input  rom_in, rom0_w, rom_w, out_ready,
    output out_valid, out_data, out_idx, out_last
  );
endinterface

`default_nettype wire

// File: rtl/horizontal_frame_buffer.sv
// ============================================================================
// Module      : horizontal_frame_buffer
// Description : Collects one horizontal frame of 60 words from the router's
//               eight lanes into register storage, then drains it in
//               bank-major order over a valid/ready stream.
// Ports       : clk       clock
//               rst_n     asynchronous reset, active HIGH (rst_n=1 resets)
//               bus       horizontal_frame_buffer_if.slave (lanes + drain)
//               ovf_clr   clears the sticky overflow flag
//               busy      high whenever the buffer is not idle
//               overflow  sticky flag for any dropped or illegal write
//               zero_err  (HFB_ZERO_CHECK_EN only) sticky flag for nonzero
//                         lane data seen while that lane's code is 0
// Options     : define HFB_ZERO_CHECK_EN to add the zero_err output/check
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module horizontal_frame_buffer #(
  parameter int P_WIDTH   = 64,
  parameter int ENTRIES   = 60,
  parameter int IDX_WIDTH = 6
) (
  input  logic                            clk,
  input  logic                            rst_n,
  horizontal_frame_buffer_if.slave        bus,
  input  logic                            ovf_clr,
  output logic                            busy,
`ifdef HFB_ZERO_CHECK_EN
  output logic                            zero_err,
`endif
  output logic                            overflow
);

  // 15 sub-banks of 4: sub 0 is bank0 A, sub 2K-1 is bank K A, sub 2K is
  // bank K B. Storage address {sub, ptr} therefore equals the drain order.
  localparam int NSUB = ENTRIES / 4;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(ENTRIES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t               state;
  logic [P_WIDTH-1:0]   mem [ENTRIES];
  logic [1:0]           ptr [NSUB];
  logic [2:0]           cnt [NSUB];
  logic [5:0]           total;
  logic [IDX_WIDTH-1:0] rd_idx;

  logic [NSUB-1:0]      wr_en;
  logic [3:0]           add;
  logic [3:0]           sub_sel;
  logic                 err;
  logic [5:0]           total_n;

  // Decode lane codes into per-sub-bank write enables. Each lane owns its
  // bank, so no two lanes can ever target the same sub-bank.
  always_comb begin
    wr_en   = '0;
    add     = '0;
    err     = 1'b0;
    sub_sel = '0;
    if (bus.rom0_w) begin
      if (state == DRAIN || cnt[0] == 3'd4) begin
        err = 1'b1;
      end else begin
        wr_en[0] = 1'b1;
        add      = add + 4'd1;
      end
    end
    for (int k = 1; k < 8; k++) begin
      sub_sel = (bus.rom_w[k] == 2'd1) ? 4'(2 * k - 1) : 4'(2 * k);
      if (bus.rom_w[k] != 2'd0) begin
        if (state == DRAIN || bus.rom_w[k] == 2'd3 || cnt[sub_sel] == 3'd4) begin
          err = 1'b1;
        end else begin
          wr_en[sub_sel] = 1'b1;
          add            = add + 4'd1;
        end
      end
    end
  end

  assign total_n = total + {2'b00, add};

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state    <= IDLE;
      total    <= '0;
      rd_idx   <= '0;
      overflow <= 1'b0;
      for (int s = 0; s < NSUB; s++) begin
        ptr[s] <= '0;
        cnt[s] <= '0;
      end
      for (int e = 0; e < ENTRIES; e++) begin
        mem[e] <= '0;
      end
    end else begin
      for (int s = 0; s < NSUB; s++) begin
        if (wr_en[s]) begin
          mem[{4'(s), ptr[s]}] <= bus.rom_in[(s + 1) / 2];
          ptr[s]               <= ptr[s] + 2'd1;
          cnt[s]               <= cnt[s] + 3'd1;
        end
      end

      case (state)
        IDLE: begin
          total <= total_n;
          if (add != 4'd0) state <= FILL;
        end
        FILL: begin
          total <= total_n;
          if (total_n == 6'(ENTRIES)) state <= DRAIN;
        end
        DRAIN: begin
          if (bus.out_ready) begin
            if (rd_idx == LAST_IDX) begin
              // Frame fully handed off: rewind everything for the next one.
              rd_idx <= '0;
              total  <= '0;
              state  <= IDLE;
              for (int s = 0; s < NSUB; s++) begin
                ptr[s] <= '0;
                cnt[s] <= '0;
              end
            end else begin
              rd_idx <= rd_idx + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // A new drop in the same cycle wins over a clear request.
      if (err)          overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

`ifdef HFB_ZERO_CHECK_EN
  // Upstream router must zero-gate lanes that are not writing.
  logic zero_viol;

  always_comb begin
    zero_viol = (!bus.rom0_w && bus.rom_in[0] != '0);
    for (int k = 1; k < 8; k++) begin
      if (bus.rom_w[k] == 2'd0 && bus.rom_in[k] != '0) zero_viol = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)          zero_err <= 1'b0;
    else if (zero_viol) zero_err <= 1'b1;
    else if (ovf_clr)   zero_err <= 1'b0;
  end
`endif

  assign busy          = (state != IDLE);
  assign bus.out_valid = (state == DRAIN);
  assign bus.out_idx   = rd_idx;
  assign bus.out_last  = (rd_idx == LAST_IDX);
  assign bus.out_data  = mem[rd_idx];

endmodule

`default_nettype wire

// File: tb/tb_horizontal_frame_buffer.sv
// ============================================================================
// Module      : tb_horizontal_frame_buffer
// Description : Directed self-checking bench for horizontal_frame_buffer.
//               Expected drain words come from closed-form formulas of the
//               fill patterns driven below.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_horizontal_frame_buffer;
  localparam int P_WIDTH   = 64;
  localparam int IDX_WIDTH = 6;

  logic clk     = 1'b0;
  logic rst_n   = 1'b1;
  logic ovf_clr = 1'b0;
  logic busy;
  logic overflow;
`ifdef HFB_ZERO_CHECK_EN
  logic zero_err;
`endif

  int tests = 0;
  int fails = 0;

  horizontal_frame_buffer_if #(.P_WIDTH(P_WIDTH), .IDX_WIDTH(IDX_WIDTH)) bus ();

  horizontal_frame_buffer #(
    .P_WIDTH  (P_WIDTH),
    .ENTRIES  (60),
    .IDX_WIDTH(IDX_WIDTH)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave),
    .ovf_clr (ovf_clr),
    .busy    (busy),
`ifdef HFB_ZERO_CHECK_EN
    .zero_err(zero_err),
`endif
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time exhausted, required completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.rom_in = '0;
    bus.rom0_w = 1'b0;
    bus.rom_w  = '0;
  endtask

  // Router pattern for one 16-cycle frame, lane value 0x100*K + cycle.
  task automatic drive_std(input int c);
    clear_in();
    if (c % 4 == 0) begin
      bus.rom0_w    = 1'b1;
      bus.rom_in[0] = 64'(c);
    end
    for (int k = 1; k < 8; k++) begin
      if ((c + k) % 2 == 0) begin
        bus.rom_w[k]  = (c < 8) ? 2'd1 : 2'd2;
        bus.rom_in[k] = 64'(256 * k + c);
      end
    end
  endtask

  function automatic logic [63:0] exp_word(input int mode, input int idx);
    int j, k, e, b;
    if (mode == 0) begin
      if (idx < 4) return 64'(4 * idx);
      j = idx - 4; k = j / 8 + 1; b = ((j % 8) >= 4) ? 1 : 0; e = j % 4;
      return 64'(256 * k + 2 * e + (k % 2) + 8 * b);
    end
    if (idx < 4) return 64'(32'h1000 + idx);
    if (idx < 8) return 64'(32'hA0 + idx - 4);
    j = idx - 4; k = j / 8 + 1; b = ((j % 8) >= 4) ? 1 : 0; e = j % 4;
    return 64'(32'h1000 + 256 * k + 4 * b + e);
  endfunction

  task automatic fill_std(input bit chk);
    for (int c = 0; c < 16; c++) begin
      drive_std(c);
      step();
      if (chk && c == 0) begin
        tests++;
        if (busy !== 1'b1) begin
          fails++; $display("FAIL fill_busy: busy=%b required 1", busy);
        end
      end
      if (chk && c == 14) begin
        tests++;
        if (bus.out_valid !== 1'b0) begin
          fails++; $display("FAIL early_valid: out_valid=%b required 0", bus.out_valid);
        end
      end
    end
    clear_in();
    if (chk) begin
      tests++;
      if (bus.out_valid !== 1'b1) begin
        fails++; $display("FAIL valid_after_fill: out_valid=%b required 1", bus.out_valid);
      end
    end
  endtask

  task automatic drain(input int mode, input bit bp, input bit wr, input int n_hs);
    int hs = 0;
    int cyc = 0;
    while (hs < n_hs && cyc < 400) begin
      bus.out_ready = bp ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
      if (wr) begin
        bus.rom0_w = 1'b1; bus.rom_in[0] = 64'hDEAD;
        bus.rom_w[1] = 2'd1; bus.rom_in[1] = 64'hBEEF;
      end
      tests++;
      if (bus.out_valid !== 1'b1 || bus.out_idx !== IDX_WIDTH'(hs) ||
          bus.out_data !== exp_word(mode, hs) || bus.out_last !== (hs == 59)) begin
        fails++;
        $display("FAIL drain_word hs=%0d: valid=%b idx=%0d data=%h last=%b, required valid=1 idx=%0d data=%h last=%b",
                 hs, bus.out_valid, bus.out_idx, bus.out_data, bus.out_last,
                 hs, exp_word(mode, hs), (hs == 59));
      end
      if (bus.out_ready) hs++;
      step();
      cyc++;
    end
    bus.out_ready = 1'b0;
    clear_in();
    tests++;
    if (hs != n_hs) begin
      fails++; $display("FAIL drain_handshakes: got %0d required %0d", hs, n_hs);
    end
  endtask

  task automatic check_idle(input string name);
    tests++;
    if (busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      fails++; $display("FAIL %s: busy=%b valid=%b required 0 0", name, busy, bus.out_valid);
    end
  endtask

  task automatic check_ovf(input string name, input logic req);
    tests++;
    if (overflow !== req) begin
      fails++; $display("FAIL %s: overflow=%b required %b", name, overflow, req);
    end
  endtask

  task automatic pulse_clr();
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
  endtask

  task automatic test_reset();
    clear_in();
    bus.out_ready = 1'b0;
    rst_n = 1'b1;
    repeat (3) step();
    rst_n = 1'b0;
    step();
    check_idle("reset_idle");
    check_ovf("reset_overflow", 1'b0);
    tests++;
    if (bus.out_idx !== 6'd0 || bus.out_last !== 1'b0 || bus.out_data !== 64'd0) begin
      fails++;
      $display("FAIL reset_outputs: idx=%0d last=%b data=%h required 0 0 0",
               bus.out_idx, bus.out_last, bus.out_data);
    end
  endtask

  task automatic test_frame();
    fill_std(1'b1);
    drain(0, 1'b0, 1'b0, 60);
    check_idle("frame_end_idle");
    check_ovf("frame_overflow", 1'b0);
  endtask

  task automatic test_backpressure();
    fill_std(1'b0);
    drain(0, 1'b1, 1'b0, 60);
    check_idle("bp_end_idle");
  endtask

  task automatic test_bank_overflow();
    for (int i = 0; i < 5; i++) begin
      clear_in();
      bus.rom_w[1]  = 2'd1;
      bus.rom_in[1] = 64'(32'hA0 + i);
      step();
      if (i == 3) check_ovf("bank_ovf_before_fifth", 1'b0);
    end
    clear_in();
    check_ovf("bank_ovf_fifth", 1'b1);
    pulse_clr();
    check_ovf("bank_ovf_cleared", 1'b0);
    for (int c = 0; c < 8; c++) begin
      clear_in();
      if (c < 4) begin
        bus.rom0_w = 1'b1; bus.rom_in[0] = 64'(32'h1000 + c);
      end else begin
        bus.rom_w[1] = 2'd2; bus.rom_in[1] = 64'(32'h1100 + c);
      end
      for (int k = 2; k < 8; k++) begin
        bus.rom_w[k]  = (c < 4) ? 2'd1 : 2'd2;
        bus.rom_in[k] = 64'(32'h1000 + 256 * k + c);
      end
      step();
    end
    clear_in();
    check_ovf("bank_ovf_rest", 1'b0);
    drain(1, 1'b0, 1'b0, 60);
    check_idle("bank_ovf_end_idle");
  endtask

  task automatic test_illegal_code();
    clear_in();
    bus.rom_w[3]  = 2'd3;
    bus.rom_in[3] = 64'h333;
    step();
    clear_in();
    check_ovf("code3_overflow", 1'b1);
    check_idle("code3_no_write");
    pulse_clr();
    check_ovf("code3_cleared", 1'b0);
  endtask

  task automatic test_drain_write();
    fill_std(1'b0);
    drain(0, 1'b0, 1'b1, 60);
    check_ovf("drain_write_overflow", 1'b1);
    check_idle("drain_write_end_idle");
    pulse_clr();
    fill_std(1'b0);
    drain(0, 1'b0, 1'b0, 60);
    check_ovf("drain_write_next_frame", 1'b0);
  endtask

  task automatic test_reset_mid_drain();
    fill_std(1'b0);
    drain(0, 1'b0, 1'b1, 20);
    tests++;
    if (bus.out_idx !== 6'd20 || overflow !== 1'b1) begin
      fails++; $display("FAIL mid_drain_pre: idx=%0d ovf=%b required 20 1", bus.out_idx, overflow);
    end
    #2;
    rst_n = 1'b1;
    #1;
    check_idle("async_reset_idle");
    check_ovf("async_reset_overflow", 1'b0);
    tests++;
    if (bus.out_idx !== 6'd0) begin
      fails++; $display("FAIL async_reset_idx: idx=%0d required 0", bus.out_idx);
    end
    @(negedge clk);
    rst_n = 1'b0;
    step();
    fill_std(1'b0);
    drain(0, 1'b0, 1'b0, 60);
    check_idle("after_reset_end_idle");
  endtask

  initial begin
    test_reset();
    test_frame();
    test_backpressure();
    test_bank_overflow();
    test_illegal_code();
    test_drain_write();
    test_reset_mid_drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
